riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
- Instruction-fetch stage of the 32-bit single-cycle RISC-V core. Sits directly upstream of the main decode controller.
- Holds the PC and fetches one instruction word per step over a req/ack instruction-memory interface.
- Presents the instruction, with `opcode = instr[6:0]` feeding the controller's opcode input.
- Computes the next PC from the branch/jump outcome returned by the execute datapath.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- WAIT_LIMIT, 16, maximum cycles to wait for imem_ack before flagging a timeout.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  XLEN  word-aligned fetch address.
- imem_ack  input  1  read data valid this cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  registered instruction presented to decode.
- opcode  output  7  instr[6:0], to the controller.
- pc  output  XLEN  address of instr.
- pc_plus4  output  XLEN  pc+4, the link value for JAL.
- instr_valid  output  1  instr/pc are valid and awaiting retirement.
- advance  input  1  execute has completed instr; fetch next.
- branch_en  input  1  controller branch output.
- branch_taken  input  1  ALU comparison result.
- jump_en  input  1  controller J_Type output.
- target_addr  input  XLEN  branch/jump target from the adder.
- fault  output  1  sticky: misaligned target or fetch timeout.
- instret  output  32  retired-instruction counter.

Behaviour:
- All registers update on the rising clk edge. reset has priority over every other input.
- Reset values:
  - pc = RESET_PC; instr = 32'h0000_0013 (NOP), so the decoder sees a legal opcode.
  - instr_valid = 0, imem_req = 0, fault = 0, instret = 0, wait counter = 0, state = IDLE.
- Combinational outputs: opcode = instr[6:0]; pc_plus4 = pc + 4, modulo 2^XLEN; imem_addr = pc.
- State machine, states IDLE, FETCH, ISSUE, HALT:
  - IDLE: lasts exactly one cycle after reset deasserts, then → FETCH.
  - FETCH:
    - imem_req = 1; wait counter increments each cycle.
    - On imem_ack: instr ← imem_rdata, instr_valid ← 1, counter cleared, → ISSUE. An ack in the first FETCH cycle (zero-wait memory) is legal.
    - If the counter reaches WAIT_LIMIT without ack: fault ← 1, → HALT.
  - ISSUE:
    - imem_req = 0; instr_valid = 1; instr and pc are stable.
    - advance = 1: instret += 1 (wraps at 2^32), instr_valid ← 0, pc ← next_pc, → FETCH.
    - advance = 0: hold indefinitely.
  - HALT: imem_req = 0, instr_valid = 0, fault = 1. Only reset exits HALT.
- next_pc priority:
  - jump_en = 1 → target_addr.
  - else branch_en & branch_taken → target_addr.
  - else pc + 4.
  - jump_en and branch_en both high: the jump wins.
  - Branch/jump inputs are sampled only in ISSUE when advance = 1; they are ignored otherwise.
- Misaligned target: a selected target_addr with [1:0] ≠ 0 sets fault ← 1, leaves pc unchanged, and goes → HALT. instret still increments because the branch/jump instruction itself retired.
- PC wrap: pc + 4 wraps from 32'hFFFF_FFFC to 0 silently.
- Input rules:
  - imem_ack outside FETCH is ignored.
  - advance outside ISSUE is ignored.
  - imem_req never asserts in the same cycle reset is high.
- Reset mid-fetch: imem_req drops the cycle after reset is sampled, and a late ack is ignored. Memory must tolerate an abandoned request.
- Latency: minimum 2 cycles per instruction (FETCH with immediate ack, then ISSUE with immediate advance).

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN;
  - NOP_INSTR = 32'h0000_0013;
  - opcode constants (OP_RTYPE 0110011, OP_ITYPE 0010011, OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111, OP_LUI 0110111, OP_AUIPC 0010111), which the controller also uses;
  - the fetch state enum.
- One sub-module, riscv_next_pc: purely combinational next-PC select plus misalignment check. The FSM, counters and registers stay in the top module.

Test Plan:
1. Reset release with RESET_PC=0 and zero-wait ack returning 32'h00500093 → imem_addr=0; instr_valid rises 2 cycles after reset; opcode=7'b0010011; pc_plus4=4.
2. Three sequential advances, no branch → pc steps 0→4→8→C; instret=3; one imem_req per instruction.
3. At pc=8: branch_en=1, branch_taken=1, target=32'h40 → next fetch address 32'h40. Same with branch_taken=0 → 32'hC.
4. jump_en=1 and branch_en=1 together, target=32'h100 → pc=32'h100. Then target=32'h102 → fault=1, HALT, imem_req stays 0, pc held.
5. imem_ack withheld for WAIT_LIMIT cycles → fault=1 and HALT. Separately, reset asserted on the third wait cycle → pc=RESET_PC, imem_req=0 next cycle, and a late ack produces no instr_valid.
6. pc=32'hFFFF_FFFC with advance and no branch → pc wraps to 0; advance held low for 10 cycles in ISSUE → instr, pc and instr_valid are stable throughout.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core: widths, opcode map and
// the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Opcodes shared with the main decode controller
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory read channel: one outstanding word request, acknowledged
// by imem_ack together with the data.
interface riscv_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/riscv_next_pc.sv
// Next-PC select for the fetch stage: jump beats branch beats sequential, and a
// selected target that is not word-aligned is reported instead of being used.
module riscv_next_pc
    import riscv_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc_plus4,
    input  logic [AW-1:0] target_addr,
    input  logic          branch_en,
    input  logic          branch_taken,
    input  logic          jump_en,
    output logic [AW-1:0] next_pc,
    output logic          misaligned
);

    logic take_target_s;

    // Select the successor address and flag unusable targets
    always_comb begin
        take_target_s = jump_en || (branch_en && branch_taken);
        next_pc       = pc_plus4;
        misaligned    = 1'b0;
        if (take_target_s) begin
            next_pc    = target_addr;
            misaligned = !word_aligned(target_addr[1:0]);
        end else begin
            next_pc    = pc_plus4;
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction over
// the req/ack channel and steps the PC when execute retires the instruction.
module riscv_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              WAIT_LIMIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    riscv_fetch_unit_if.master  imem,
    output logic [31:0]         instr,
    output logic [6:0]          opcode,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                instr_valid,
    input  logic                advance,
    input  logic                branch_en,
    input  logic                branch_taken,
    input  logic                jump_en,
    input  logic [XLEN-1:0]     target_addr,
    output logic                fault,
    output logic [31:0]         instret
);
    import riscv_pkg::fetch_state_t;
    import riscv_pkg::ST_IDLE;
    import riscv_pkg::ST_FETCH;
    import riscv_pkg::ST_ISSUE;
    import riscv_pkg::ST_HALT;
    import riscv_pkg::NOP_INSTR;

    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    fetch_state_t    state_r;
    fetch_state_t    state_next_s;
    logic [WCW-1:0]  wait_cnt_r;
    logic [31:0]     instr_r;
    logic [XLEN-1:0] pc_r;
    logic            instr_valid_r;
    logic            fault_r;
    logic [31:0]     instret_r;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] next_pc_s;
    logic            misaligned_s;
    logic            ack_s;
    logic            timeout_s;
    logic            retire_s;
    logic            req_s;

    assign pc_plus4_s = pc_r + XLEN'(32'd4);
    assign ack_s      = (state_r == ST_FETCH) && imem.imem_ack;
    assign timeout_s  = (state_r == ST_FETCH) && !imem.imem_ack &&
                        (wait_cnt_r == WCW'(WAIT_LIMIT - 1));
    assign retire_s   = (state_r == ST_ISSUE) && advance;

    riscv_next_pc #(
        .AW (XLEN)
    ) u_next_pc (
        .pc_plus4     (pc_plus4_s),
        .target_addr  (target_addr),
        .branch_en    (branch_en),
        .branch_taken (branch_taken),
        .jump_en      (jump_en),
        .next_pc      (next_pc_s),
        .misaligned   (misaligned_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    state_next_s = ST_ISSUE;
                end else if (timeout_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (advance) begin
                    state_next_s = misaligned_s ? ST_HALT : ST_FETCH;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Request decode; gated by reset so an abandoned fetch never overlaps reset
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            ST_FETCH: req_s = !reset;
            ST_IDLE:  req_s = 1'b0;
            ST_ISSUE: req_s = 1'b0;
            ST_HALT:  req_s = 1'b0;
            default:  req_s = 1'b0;
        endcase
    end

    // Instruction, PC, wait counter, fault and retirement registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= RESET_PC;
            instr_r       <= NOP_INSTR;
            instr_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            instret_r     <= 32'd0;
            wait_cnt_r    <= '0;
        end else begin
            if (ack_s) begin
                instr_r       <= imem.imem_rdata;
                instr_valid_r <= 1'b1;
                wait_cnt_r    <= '0;
            end else if (state_r == ST_FETCH) begin
                wait_cnt_r <= wait_cnt_r + WCW'(1'b1);
                if (timeout_s) begin
                    fault_r <= 1'b1;
                end
            end
            // The branch/jump retires even when its target is rejected
            if (retire_s) begin
                instret_r     <= instret_r + 32'd1;
                instr_valid_r <= 1'b0;
                if (misaligned_s) begin
                    fault_r <= 1'b1;
                end else begin
                    pc_r <= next_pc_s;
                end
            end
        end
    end

    assign imem.imem_req  = req_s;
    assign imem.imem_addr = pc_r;
    assign instr          = instr_r;
    assign opcode         = instr_r[6:0];
    assign pc             = pc_r;
    assign pc_plus4       = pc_plus4_s;
    assign instr_valid    = instr_valid_r;
    assign fault          = fault_r;
    assign instret        = instret_r;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed plus randomized bench for riscv_fetch_unit against an
// instruction-level reference model (expected PC, word, retire count, fault).
module tb_riscv_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance, branch_en, branch_taken, jump_en;
    logic [31:0] target_addr;
    logic [31:0] instr, pc, pc_plus4, instret;
    logic [6:0]  opcode;
    logic        instr_valid, fault;

    riscv_fetch_unit_if #(.XLEN(32)) imem_bus ();

    riscv_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .WAIT_LIMIT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem_bus),
        .instr        (instr),
        .opcode       (opcode),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .advance      (advance),
        .branch_en    (branch_en),
        .branch_taken (branch_taken),
        .jump_en      (jump_en),
        .target_addr  (target_addr),
        .fault        (fault),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc, exp_instr, exp_instret;
    logic        exp_fault;
    logic [6:0]  op_table [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Puts the DUT into reset, checks reset values, and leaves it in its first FETCH cycle
    task automatic do_reset;
        reset = 1'b1;
        advance = 1'b0; branch_en = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
        target_addr = 32'd0;
        imem_bus.imem_ack = 1'b0;
        #1;
        check("req_during_reset", {31'd0, imem_bus.imem_req}, 32'd0);
        tick;
        tick;
        exp_pc = 32'd0; exp_instr = NOP_INSTR; exp_instret = 32'd0; exp_fault = 1'b0;
        check("rst_pc", pc, exp_pc);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_instret", instret, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_req", {31'd0, imem_bus.imem_req}, 32'd0);
        tick;
    endtask

    // Serves one fetch after `waits` unacknowledged request cycles
    task automatic do_fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i < waits; i++) begin
            check("wait_req", {31'd0, imem_bus.imem_req}, 32'd1);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            tick;
        end
        check("fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
        check("fetch_addr", imem_bus.imem_addr, exp_pc);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = word;
        tick;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = $urandom;
        exp_instr = word;
        check("issue_valid", {31'd0, instr_valid}, 32'd1);
        check("issue_instr", instr, exp_instr);
        check("issue_opcode", {25'd0, opcode}, {25'd0, word[6:0]});
        check("issue_pc", pc, exp_pc);
        check("issue_pc_plus4", pc_plus4, exp_pc + 32'd4);
        check("issue_req", {31'd0, imem_bus.imem_req}, 32'd0);
    endtask

    // Holds ISSUE for `hold` cycles with ignored noise, then retires with the given outcome
    task automatic do_retire(input logic br, input logic tk, input logic jmp,
                             input logic [31:0] tgt, input int hold);
        for (int i = 0; i < hold; i++) begin
            branch_en = 1'($urandom); branch_taken = 1'($urandom); jump_en = 1'($urandom);
            target_addr = $urandom;
            imem_bus.imem_ack = 1'($urandom);
            tick;
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_instr", instr, exp_instr);
            check("hold_pc", pc, exp_pc);
        end
        imem_bus.imem_ack = 1'b0;
        advance = 1'b1; branch_en = br; branch_taken = tk; jump_en = jmp; target_addr = tgt;
        tick;
        advance = 1'b0; branch_en = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
        exp_instret = exp_instret + 32'd1;
        if (jmp || (br && tk)) begin
            if (tgt[1:0] != 2'b00) exp_fault = 1'b1;
            else exp_pc = tgt;
        end else begin
            exp_pc = exp_pc + 32'd4;
        end
        check("retire_instret", instret, exp_instret);
        check("retire_valid", {31'd0, instr_valid}, 32'd0);
        check("retire_pc", pc, exp_pc);
        check("retire_fault", {31'd0, fault}, {31'd0, exp_fault});
        check("retire_req", {31'd0, imem_bus.imem_req}, {31'd0, !exp_fault});
    endtask

    function automatic logic [31:0] rand_word;
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], op_table[$urandom_range(0, 7)]};
    endfunction

    initial begin
        logic [31:0] tgt;
        int          kind;
        op_table[0] = OP_RTYPE;  op_table[1] = OP_ITYPE; op_table[2] = OP_LOAD;
        op_table[3] = OP_STORE;  op_table[4] = OP_BRANCH; op_table[5] = OP_JAL;
        op_table[6] = OP_LUI;    op_table[7] = OP_AUIPC;
        imem_bus.imem_rdata = 32'd0;

        // Reset release, zero-wait first fetch
        do_reset;
        do_fetch(0, 32'h0050_0093);
        check("t1_opcode_itype", {25'd0, opcode}, {25'd0, OP_ITYPE});
        check("t1_pc_plus4", pc_plus4, 32'd4);

        // Sequential execution 0 -> 4 -> 8 -> C
        do_retire(1'b0, 1'b0, 1'b0, 32'd0, 0);
        do_fetch(1, rand_word());
        do_retire(1'b0, 1'b0, 1'b0, 32'd0, 1);
        do_fetch(2, rand_word());
        do_retire(1'b0, 1'b0, 1'b0, 32'd0, 0);
        check("t2_pc", pc, 32'h0000_000C);
        check("t2_instret", instret, 32'd3);

        // Branch taken and not taken from pc=8
        do_fetch(0, rand_word());
        do_retire(1'b0, 1'b0, 1'b1, 32'h0000_0008, 0);
        do_fetch(0, rand_word());
        do_retire(1'b1, 1'b1, 1'b0, 32'h0000_0040, 0);
        check("t3_taken_addr", imem_bus.imem_addr, 32'h0000_0040);
        do_fetch(0, rand_word());
        do_retire(1'b0, 1'b0, 1'b1, 32'h0000_0008, 0);
        do_fetch(0, rand_word());
        do_retire(1'b1, 1'b0, 1'b0, 32'h0000_0040, 0);
        check("t3_not_taken_addr", imem_bus.imem_addr, 32'h0000_000C);

        // Jump beats branch, then a misaligned jump halts
        do_fetch(0, rand_word());
        do_retire(1'b1, 1'b1, 1'b1, 32'h0000_0100, 0);
        check("t4_jump_pc", pc, 32'h0000_0100);
        do_fetch(1, rand_word());
        do_retire(1'b0, 1'b0, 1'b1, 32'h0000_0102, 0);
        for (int i = 0; i < 5; i++) begin
            imem_bus.imem_ack = 1'b1; advance = 1'b1; jump_en = 1'b1; target_addr = 32'h0000_0200;
            tick;
            check("halt_req", {31'd0, imem_bus.imem_req}, 32'd0);
            check("halt_pc", pc, 32'h0000_0100);
            check("halt_fault", {31'd0, fault}, 32'd1);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_instret", instret, exp_instret);
        end
        imem_bus.imem_ack = 1'b0; advance = 1'b0; jump_en = 1'b0;

        // PC wrap and a long ISSUE hold
        do_reset;
        do_fetch(0, rand_word());
        do_retire(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 0);
        do_fetch(0, rand_word());
        check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        do_retire(1'b0, 1'b0, 1'b0, 32'd0, 10);
        check("wrap_pc", pc, 32'h0000_0000);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom_range(0, 3), rand_word());
            kind = $urandom_range(0, 3);
            tgt = $urandom & 32'hFFFF_FFFC;
            case (kind)
                0: do_retire(1'b0, 1'($urandom), 1'b0, tgt, $urandom_range(0, 2));
                1: do_retire(1'b1, 1'b1, 1'b0, tgt, $urandom_range(0, 2));
                2: do_retire(1'b1, 1'b0, 1'b0, tgt, $urandom_range(0, 2));
                default: do_retire(1'($urandom), 1'($urandom), 1'b1, tgt, $urandom_range(0, 2));
            endcase
        end

        // Fetch timeout after WAIT_LIMIT unacknowledged cycles
        do_reset;
        check("to_req_first", {31'd0, imem_bus.imem_req}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick;
            check("to_req", {31'd0, imem_bus.imem_req}, 32'd1);
            check("to_no_fault", {31'd0, fault}, 32'd0);
        end
        tick;
        check("to_fault", {31'd0, fault}, 32'd1);
        check("to_req_drop", {31'd0, imem_bus.imem_req}, 32'd0);
        imem_bus.imem_ack = 1'b1;
        tick;
        tick;
        check("to_late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("to_late_ack_fault", {31'd0, fault}, 32'd1);
        imem_bus.imem_ack = 1'b0;

        // Reset in the third wait cycle abandons the fetch
        do_reset;
        tick;
        tick;
        check("mid_req_before", {31'd0, imem_bus.imem_req}, 32'd1);
        reset = 1'b1;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("mid_req_same_cycle", {31'd0, imem_bus.imem_req}, 32'd0);
        tick;
        check("mid_req_after", {31'd0, imem_bus.imem_req}, 32'd0);
        check("mid_pc", pc, 32'h0000_0000);
        reset = 1'b0;
        tick;
        imem_bus.imem_ack = 1'b0;
        check("mid_late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_late_ack_instr", instr, NOP_INSTR);
        check("mid_refetch_req", {31'd0, imem_bus.imem_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
